ddr_mp_burst_ctrl: RTL and testbench

Multi-port DDR burst controller: a parametrised successor to the single-port burst engine. It accepts read/write burst requests from NUM_PORTS independent clients and arbitrates between them round-robin. It runs each granted burst against the MIG-style app_* user interface and routes write-data requests, read data and finish pulses back to the granted port only. It sits between the cache/AP memory clients and the DDR IP core.

---
 rtl/ddr_mp_burst_ctrl_if.sv | 67 ++++++
 rtl/ddr_mp_burst_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_ddr_mp_burst_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_mp_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_mp_burst_ctrl_if
//  Description : Client request/response bus plus MIG app_* user interface
//                bundled for the multi-port DDR burst controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ddr_mp_burst_ctrl_if #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int NUM_PORTS      = 2
);
  // Controller-wide status from the DDR IP
  logic                                 init_calib_complete;

  // Client request side
  logic [NUM_PORTS-1:0]                 rd_req;
  logic [NUM_PORTS-1:0]                 wr_req;
  logic [NUM_PORTS*10-1:0]              rd_len;
  logic [NUM_PORTS*10-1:0]              wr_len;
  logic [NUM_PORTS*DDR_ADDR_WIDTH-1:0]  rd_addr;
  logic [NUM_PORTS*DDR_ADDR_WIDTH-1:0]  wr_addr;
  logic [NUM_PORTS*DDR_DATA_WIDTH-1:0]  wr_data;

  // Client response side
  logic [NUM_PORTS-1:0]                 wr_data_req;
  logic [DDR_DATA_WIDTH-1:0]            rd_data;
  logic [NUM_PORTS-1:0]                 rd_data_valid;
  logic [NUM_PORTS-1:0]                 rd_finish;
  logic [NUM_PORTS-1:0]                 wr_finish;
  logic [NUM_PORTS-1:0]                 grant;
  logic                                 busy;

  // MIG user interface, controller drive
  logic [DDR_ADDR_WIDTH-1:0]            app_addr;
  logic [2:0]                           app_cmd;
  logic                                 app_en;
  logic [DDR_DATA_WIDTH-1:0]            app_wdf_data;
  logic                                 app_wdf_end;
  logic [DDR_DATA_WIDTH/8-1:0]          app_wdf_mask;
  logic                                 app_wdf_wren;

  // MIG user interface, DDR IP returns
  logic [DDR_DATA_WIDTH-1:0]            app_rd_data;
  logic                                 app_rd_data_valid;
  logic                                 app_rdy;
  logic                                 app_wdf_rdy;

  // Controller view: serves client requests, drives the app_* command side
  modport slave (
    input  init_calib_complete,
    input  rd_req, wr_req, rd_len, wr_len, rd_addr, wr_addr, wr_data,
    output wr_data_req, rd_data, rd_data_valid, rd_finish, wr_finish, grant, busy,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
    input  app_rd_data, app_rd_data_valid, app_rdy, app_wdf_rdy
  );

  // Environment view: clients plus DDR IP
  modport master (
    output init_calib_complete,
    output rd_req, wr_req, rd_len, wr_len, rd_addr, wr_addr, wr_data,
    input  wr_data_req, rd_data, rd_data_valid, rd_finish, wr_finish, grant, busy,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
    output app_rd_data, app_rd_data_valid, app_rdy, app_wdf_rdy
  );
endinterface
`default_nettype wire

// File: rtl/ddr_mp_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_mp_burst_ctrl
//  Description : Round-robin multi-port DDR burst controller. Grants one
//                client at a time, issues its burst on the MIG app_* bus and
//                routes write-data requests, read data and finish pulses to
//                the granted port only.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_mp_burst_ctrl #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_STRIDE    = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ddr_mp_burst_ctrl_if.slave bus
);

  localparam int         PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [2:0] CMD_READ   = 3'b001;
  localparam logic [2:0] CMD_WRITE  = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_RUN  = 3'd1,
    RD_WAIT = 3'd2,
    WR_RUN  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_PORTS-1:0]      grant_q, grant_d;
  logic                      dir_rd_q, dir_rd_d;
  logic [9:0]                len_q, len_d;
  logic [9:0]                cmd_cnt_q, cmd_cnt_d;
  logic [9:0]                data_cnt_q, data_cnt_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]                cmd_q, cmd_d;
  logic                      en_q, en_d;
  logic [PW-1:0]             rr_q, rr_d;

  logic                      found;
  logic [PW-1:0]             win;
  logic [NUM_PORTS-1:0]      win_onehot;
  logic [PW:0]               scan_idx;
  logic                      cmd_acc;
  logic                      wr_fire;
  logic                      rd_beat;
  logic [DDR_DATA_WIDTH-1:0] wdata_mux;

  // Gated handshake qualifiers; nothing counts while calibration is pending.
  assign cmd_acc = bus.init_calib_complete & en_q & bus.app_rdy;
  assign wr_fire = bus.init_calib_complete & (state_q == WR_RUN) & bus.app_wdf_rdy
                   & (data_cnt_q < len_q);
  assign rd_beat = bus.init_calib_complete & bus.app_rd_data_valid
                   & ((state_q == RD_RUN) | (state_q == RD_WAIT));

  // Round-robin scan starting at rr_q; first requesting port wins.
  always_comb begin
    found      = 1'b0;
    win        = '0;
    win_onehot = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = {1'b0, rr_q} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(NUM_PORTS)) begin
        scan_idx = scan_idx - (PW+1)'(NUM_PORTS);
      end
      if (!found && (bus.rd_req[scan_idx[PW-1:0]] | bus.wr_req[scan_idx[PW-1:0]])) begin
        found                          = 1'b1;
        win                            = scan_idx[PW-1:0];
        win_onehot                     = '0;
        win_onehot[scan_idx[PW-1:0]]   = 1'b1;
      end
    end
  end

  // Next-state and datapath update; everything holds while calibration is low.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    dir_rd_d   = dir_rd_q;
    len_d      = len_q;
    cmd_cnt_d  = cmd_cnt_q;
    data_cnt_d = data_cnt_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    en_d       = en_q;
    rr_d       = rr_q;

    if (bus.init_calib_complete) begin
      // Command side is shared by both directions: count, stride, stop at len.
      if (cmd_acc) begin
        cmd_cnt_d = cmd_cnt_q + 10'd1;
        addr_d    = addr_q + DDR_ADDR_WIDTH'(ADDR_STRIDE);
        if ((cmd_cnt_q + 10'd1) == len_q) begin
          en_d = 1'b0;
        end
      end

      case (state_q)
        IDLE: begin
          if (found) begin
            grant_d    = win_onehot;
            rr_d       = (win == PW'(NUM_PORTS - 1)) ? '0 : (win + PW'(1));
            cmd_cnt_d  = '0;
            data_cnt_d = '0;
            // A port asking for both directions gets its read first.
            if (bus.rd_req[win]) begin
              dir_rd_d = 1'b1;
              len_d    = bus.rd_len[10*int'(win) +: 10];
              addr_d   = bus.rd_addr[DDR_ADDR_WIDTH*int'(win) +: DDR_ADDR_WIDTH];
              cmd_d    = CMD_READ;
            end else begin
              dir_rd_d = 1'b0;
              len_d    = bus.wr_len[10*int'(win) +: 10];
              addr_d   = bus.wr_addr[DDR_ADDR_WIDTH*int'(win) +: DDR_ADDR_WIDTH];
              cmd_d    = CMD_WRITE;
            end
            // Zero-length bursts skip the DDR entirely but still finish.
            if (len_d == 10'd0) begin
              en_d    = 1'b0;
              state_d = DONE;
            end else begin
              en_d    = 1'b1;
              state_d = dir_rd_d ? RD_RUN : WR_RUN;
            end
          end
        end

        RD_RUN: begin
          if (rd_beat) begin
            data_cnt_d = data_cnt_q + 10'd1;
          end
          if (rd_beat && ((data_cnt_q + 10'd1) == len_q)) begin
            state_d = DONE;
          end else if (cmd_cnt_d == len_q) begin
            state_d = RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (rd_beat) begin
            data_cnt_d = data_cnt_q + 10'd1;
            if ((data_cnt_q + 10'd1) == len_q) begin
              state_d = DONE;
            end
          end
        end

        WR_RUN: begin
          if (wr_fire) begin
            data_cnt_d = data_cnt_q + 10'd1;
            if ((data_cnt_q + 10'd1) == len_q) begin
              state_d = WR_WAIT;
            end
          end
        end

        WR_WAIT: begin
          if (cmd_cnt_d == len_q) begin
            state_d = DONE;
          end
        end

        DONE: begin
          grant_d = '0;
          en_d    = 1'b0;
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
          grant_d = '0;
          en_d    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; async reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      dir_rd_q   <= 1'b0;
      len_q      <= '0;
      cmd_cnt_q  <= '0;
      data_cnt_q <= '0;
      addr_q     <= '0;
      cmd_q      <= '0;
      en_q       <= 1'b0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      dir_rd_q   <= dir_rd_d;
      len_q      <= len_d;
      cmd_cnt_q  <= cmd_cnt_d;
      data_cnt_q <= data_cnt_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      en_q       <= en_d;
      rr_q       <= rr_d;
    end
  end

  // Write-data mux keyed on the one-hot grant, so it reads 0 when idle.
  always_comb begin
    wdata_mux = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) begin
        wdata_mux = wdata_mux | bus.wr_data[DDR_DATA_WIDTH*p +: DDR_DATA_WIDTH];
      end
    end
  end

  assign bus.app_addr      = addr_q;
  assign bus.app_cmd       = cmd_q;
  assign bus.app_en        = en_q;
  assign bus.app_wdf_data  = wdata_mux;
  assign bus.app_wdf_wren  = wr_fire;
  assign bus.app_wdf_end   = wr_fire;
  assign bus.app_wdf_mask  = '0;

  assign bus.wr_data_req   = wr_fire ? grant_q : '0;
  assign bus.rd_data       = bus.app_rd_data;
  // Read returns after an abort land with grant=0 and are dropped here.
  assign bus.rd_data_valid = bus.app_rd_data_valid ? grant_q : '0;
  assign bus.rd_finish     = ((state_q == DONE) && dir_rd_q)  ? grant_q : '0;
  assign bus.wr_finish     = ((state_q == DONE) && !dir_rd_q) ? grant_q : '0;
  assign bus.grant         = grant_q;
  assign bus.busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr_mp_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_mp_burst_ctrl
//  Description : Scoreboard bench for the multi-port DDR burst controller
//                with a 4-port client model and a fixed-latency DDR model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_mp_burst_ctrl;

  localparam int DW = 128;
  localparam int AW = 28;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  ddr_mp_burst_ctrl_if #(.DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .NUM_PORTS(NP)) u_bus ();

  ddr_mp_burst_ctrl #(
    .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .NUM_PORTS(NP), .ADDR_STRIDE(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_bus)
  );

  always #5 clk = ~clk;

  // Scoreboard queues
  logic [AW+2:0]    cq[$];   // {cmd, addr}
  logic [DW+NP+1:0] wq[$];   // {wren, end, wr_data_req, data}
  logic [DW+NP-1:0] rq[$];   // {rd_data_valid, rd_data}
  logic [3*NP-1:0]  fq[$];   // {rd_finish, wr_finish, grant}
  int               pend_due[$];
  logic [AW-1:0]    pend_addr[$];

  int  rd_cnt[NP];
  int  wr_cnt[NP];
  int  wbeat[NP];
  int  exp_k[NP];
  bit  adv[NP];
  bit  rdy_toggle = 1'b0;
  bit  wdf_toggle = 1'b0;
  bit  rdy_level  = 1'b1;
  int  last_rd_cyc = -1;
  int  vectors = 0;
  int  miscompares = 0;

  function automatic logic [DW-1:0] rdpat(input logic [AW-1:0] a);
    return {32'hDEADBEEF, 64'h0123_4567_89AB_CDEF, 4'h0, a};
  endfunction

  function automatic logic [DW-1:0] wpat(input int p, input int k);
    return {64'hC0DE_0000_FACE_0000, 32'(p), 32'(k)};
  endfunction

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] m;
    m    = '0;
    m[p] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm, input logic [159:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event got %h expected none (t=%0t)", nm, act, $time);
  endtask

  task automatic exp_fin(input int p, input bit rd);
    fq.push_back({rd ? onehot(p) : NP'(0), rd ? NP'(0) : onehot(p), onehot(p)});
  endtask

  task automatic rd_burst(input int p, input int len, input logic [AW-1:0] a);
    logic [AW-1:0] ai;
    u_bus.rd_len[p*10 +: 10]  = 10'(len);
    u_bus.rd_addr[p*AW +: AW] = a;
    rd_cnt[p]++;
    for (int i = 0; i < len; i++) begin
      ai = a + AW'(8*i);
      cq.push_back({3'b001, ai});
      rq.push_back({onehot(p), rdpat(ai)});
    end
    exp_fin(p, 1'b1);
  endtask

  task automatic wr_burst(input int p, input int len, input logic [AW-1:0] a);
    logic [AW-1:0] ai;
    u_bus.wr_len[p*10 +: 10]  = 10'(len);
    u_bus.wr_addr[p*AW +: AW] = a;
    wr_cnt[p]++;
    for (int i = 0; i < len; i++) begin
      ai = a + AW'(8*i);
      cq.push_back({3'b000, ai});
      wq.push_back({1'b1, 1'b1, onehot(p), wpat(p, exp_k[p])});
      exp_k[p]++;
    end
    exp_fin(p, 1'b0);
  endtask

  function automatic bit clients_idle();
    for (int p = 0; p < NP; p++) begin
      if (rd_cnt[p] != 0 || wr_cnt[p] != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"},   u_bus.grant,         '0);
    chk({tag, "_busy"},    u_bus.busy,          '0);
    chk({tag, "_app_en"},  u_bus.app_en,        '0);
    chk({tag, "_addr"},    u_bus.app_addr,      '0);
    chk({tag, "_cmd"},     u_bus.app_cmd,       '0);
    chk({tag, "_wren"},    {u_bus.app_wdf_wren, u_bus.app_wdf_end}, '0);
    chk({tag, "_mask"},    u_bus.app_wdf_mask,  '0);
    chk({tag, "_wdreq"},   u_bus.wr_data_req,   '0);
    chk({tag, "_rdvalid"}, u_bus.rd_data_valid, '0);
    chk({tag, "_finish"},  {u_bus.rd_finish, u_bus.wr_finish}, '0);
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      n++;
      if (cq.size() == 0 && wq.size() == 0 && rq.size() == 0 && fq.size() == 0
          && clients_idle() && !u_bus.busy) break;
      if (n >= maxc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_timeout: got cq=%0d wq=%0d rq=%0d fq=%0d busy=%0b expected all drained",
                 nm, cq.size(), wq.size(), rq.size(), fq.size(), u_bus.busy);
        cq.delete(); wq.delete(); rq.delete(); fq.delete();
        for (int p = 0; p < NP; p++) begin
          rd_cnt[p] = 0;
          wr_cnt[p] = 0;
        end
        break;
      end
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops and compares whenever the DUT presents an output event
  initial forever begin
    @(negedge clk);
    for (int p = 0; p < NP; p++) adv[p] = u_bus.wr_data_req[p];
    if (!rst) begin
      if (u_bus.app_en && u_bus.app_rdy) begin
        if (u_bus.app_cmd == 3'b001) begin
          pend_due.push_back(cyc + 3);
          pend_addr.push_back(u_bus.app_addr);
        end
        if (cq.size() == 0) unexpected("cmd", {u_bus.app_cmd, u_bus.app_addr});
        else chk("cmd", {u_bus.app_cmd, u_bus.app_addr}, cq.pop_front());
      end
      if (u_bus.app_wdf_wren || u_bus.app_wdf_end || (u_bus.wr_data_req != '0)) begin
        if (wq.size() == 0) unexpected("wbeat", u_bus.app_wdf_data);
        else chk("wbeat", {u_bus.app_wdf_wren, u_bus.app_wdf_end, u_bus.wr_data_req,
                           u_bus.app_wdf_data}, wq.pop_front());
      end
      if (u_bus.rd_data_valid != '0) begin
        last_rd_cyc = cyc;
        if (rq.size() == 0) unexpected("rbeat", {u_bus.rd_data_valid, u_bus.rd_data});
        else chk("rbeat", {u_bus.rd_data_valid, u_bus.rd_data}, rq.pop_front());
      end
      if ((u_bus.rd_finish | u_bus.wr_finish) != '0) begin
        if (fq.size() == 0) unexpected("finish", {u_bus.rd_finish, u_bus.wr_finish, u_bus.grant});
        else chk("finish", {u_bus.rd_finish, u_bus.wr_finish, u_bus.grant}, fq.pop_front());
        if (u_bus.rd_finish != '0 && last_rd_cyc >= 0) begin
          chk("rd_fin_lat", cyc - last_rd_cyc, 1);
          last_rd_cyc = -1;
        end
        for (int p = 0; p < NP; p++) begin
          if (u_bus.rd_finish[p] && rd_cnt[p] > 0) rd_cnt[p]--;
          if (u_bus.wr_finish[p] && wr_cnt[p] > 0) wr_cnt[p]--;
        end
      end
    end
  end

  // Driver: DDR model handshakes, read returns, client requests and write data
  initial forever begin
    @(posedge clk);
    #2;
    u_bus.app_rdy     = rdy_toggle ? cyc[0] : rdy_level;
    u_bus.app_wdf_rdy = wdf_toggle ? ((cyc % 3) != 1) : 1'b1;
    u_bus.app_rd_data_valid = 1'b0;
    if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      u_bus.app_rd_data_valid = 1'b1;
      u_bus.app_rd_data       = rdpat(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
    for (int p = 0; p < NP; p++) begin
      if (adv[p]) begin
        wbeat[p]++;
        adv[p] = 1'b0;
      end
      u_bus.rd_req[p] = (rd_cnt[p] > 0);
      u_bus.wr_req[p] = (wr_cnt[p] > 0);
      u_bus.wr_data[p*DW +: DW] = wpat(p, wbeat[p]);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    u_bus.init_calib_complete = 1'b0;
    u_bus.rd_req = '0; u_bus.wr_req = '0;
    u_bus.rd_len = '0; u_bus.wr_len = '0;
    u_bus.rd_addr = '0; u_bus.wr_addr = '0;
    u_bus.wr_data = '0;
    u_bus.app_rd_data = '0; u_bus.app_rd_data_valid = 1'b0;
    u_bus.app_rdy = 1'b0; u_bus.app_wdf_rdy = 1'b0;
    for (int p = 0; p < NP; p++) begin
      rd_cnt[p] = 0; wr_cnt[p] = 0; wbeat[p] = 0; exp_k[p] = 0; adv[p] = 1'b0;
    end

    repeat (2) @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Calibration pending: request must not be served yet
    rd_burst(0, 4, 28'h100);
    repeat (4) @(negedge clk);
    chk("calib_hold_busy", u_bus.busy, 0);
    chk("calib_hold_en",   u_bus.app_en, 0);
    chk("calib_hold_grant", u_bus.grant, 0);
    @(posedge clk); #1;
    u_bus.init_calib_complete = 1'b1;
    wait_done("rd4", 100);

    // Write len 3 with app_rdy toggling and app_wdf_rdy gaps
    rdy_toggle = 1'b1;
    wdf_toggle = 1'b1;
    wr_burst(1, 3, 28'h400);
    wait_done("wr3", 100);
    rdy_toggle = 1'b0;
    wdf_toggle = 1'b0;

    // Same port read+write: read first, write on a later arbitration
    rd_burst(2, 2, 28'h800);
    wr_burst(2, 1, 28'h900);
    wait_done("rdwr", 100);

    // Zero-length read: finish only, no commands
    rd_burst(3, 0, 28'h500);
    wait_done("len0", 50);

    // Address wrap
    wr_burst(0, 2, 28'hFFFFFF8);
    wait_done("wrap", 100);

    // Read with command stalls
    rdy_toggle = 1'b1;
    rd_burst(3, 3, 28'h2000);
    wait_done("rdstall", 100);
    rdy_toggle = 1'b0;

    // Reset mid-burst after two accepted commands
    u_bus.rd_len[1*10 +: 10]  = 10'd8;
    u_bus.rd_addr[1*AW +: AW] = 28'h40;
    rd_cnt[1] = 1;
    cq.push_back({3'b001, 28'h40});
    cq.push_back({3'b001, 28'h48});
    for (int n = 0; n < 50 && cq.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    chk("abort_cmds_seen", cq.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    rd_cnt[1] = 0;
    cq.delete();
    @(negedge clk);
    chk_idle("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd_cyc = -1;
    repeat (8) @(negedge clk);
    chk("abort_no_finish", fq.size(), 0);

    // Fairness: all four ports stream len-1 writes, grants rotate 0,1,2,3,0,...
    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 0; p < NP; p++) begin
        wr_burst(p, 1, 28'h1000 + AW'(p * 'h100));
      end
    end
    wait_done("fair", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
